hd_sched: RTL and testbench
===========================

HD_SCHED -- requirements
Module: hd_sched

Interface
REQ-001 The block SHALL have no parameters; all widths below are fixed.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 a_valid  input  1  requester A holds a code-word pair.
REQ-005 a_cw1, a_cw2  input  7 each  requester A code words.
REQ-006 a_ready  output  1  A pair accepted this cycle; transfer occurs when a_valid & a_ready.
REQ-007 b_valid, b_cw1, b_cw2, b_ready  SHALL mirror the A ports for requester B.
REQ-008 out_valid  output  1  one-cycle result strobe.
REQ-009 out_id  output  1  source of the result: 0 = A, 1 = B.
REQ-010 out_n  output  6  signed two's-complement result.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 err_cnt  output  8  count of corrected code words, saturating.

Function
REQ-013 Code word bit map SHALL be [6]=p1, [5]=p2, [4]=p3, [3]=x1, [2]=x2, [1]=x3, [0]=x4.
REQ-014 Syndrome SHALL be c1=p1^x1^x2^x3, c2=p2^x1^x2^x4, c3=p3^x1^x3^x4.
REQ-015 {c3,c2,c1} SHALL identify the errored bit as follows: 001 p1, 010 p2, 011 x2, 100 p3, 101 x3, 110 x4, 111 x1, 000 none.
REQ-016 Corrected data w SHALL be {x1,x2,x3,x4} with the errored bit inverted when it is a data bit; w is signed 4-bit.
REQ-017 Flag f SHALL be the received (uncorrected) value of the errored bit; f=0 when the syndrome is 000.
REQ-018 Exactly one decoder instance SHALL exist; it is time-shared between cw1 and cw2 of the captured pair.
REQ-019 Result with f1,w1 from cw1 and f2,w2 from cw2 SHALL be:
- f1=0,f2=0: 2*w1+w2
- f1=0,f2=1: 2*w1-w2
- f1=1,f2=0: w1-2*w2
- f1=1,f2=1: w1+2*w2
REQ-020 Arithmetic SHALL be performed in 6 bits after sign extension; the result range [-24,23] cannot overflow.
REQ-021 The FSM SHALL have four states: IDLE, DEC1, DEC2, DONE.
REQ-022 IDLE SHALL grant one requester per cycle by round-robin: if both are valid, the requester not granted last wins; a single valid requester wins.
REQ-023 a_ready/b_ready SHALL be combinational, asserted only in IDLE and only for the winner, and never both high.
REQ-024 On transfer the block SHALL capture cw1, cw2 and the id, update last-grant, and go to DEC1.
REQ-025 DEC1 SHALL decode cw1 into registered w1 and f1, then go to DEC2.
REQ-026 DEC2 SHALL decode cw2, compute the result, register out_n and out_id, then go to DONE.
REQ-027 In DONE, out_valid SHALL be 1; otherwise 0.
REQ-028 DONE SHALL return to IDLE unconditionally; no transfer is possible outside IDLE.
REQ-029 Latency: a transfer at edge T SHALL give out_valid high in cycle T+3; throughput is one pair per 4 cycles.
REQ-030 out_n and out_id SHALL hold their value until the next DONE.
REQ-031 err_cnt SHALL increment by 1 in DEC1 and in DEC2 for each nonzero syndrome, and saturate at 255.
REQ-032 A requester dropping valid before ready SHALL be legal; it is simply not granted.

Reset
REQ-033 rst SHALL force, asynchronously and at any state including mid-decode:
- state = IDLE
- out_valid = 0, out_n = 0, out_id = 0
- err_cnt = 0
- last-grant = B, so A wins the first tie
REQ-034 After rst, any in-flight pair SHALL be discarded with no out_valid.

Verification
REQ-035 A only: cw1=7'h75, cw2=7'h4F -> out_n=1, out_id=0, out_valid 3 cycles after transfer, err_cnt=2.
REQ-036 Flag combinations, with err_cnt rising by 1 per errored word:
- cw1=7'h55, cw2=7'h4E -> out_n=8
- cw1=7'h75, cw2=7'h4E -> out_n=9
- cw1=7'h55, cw2=7'h4F -> out_n=12
REQ-037 Extreme: cw1=cw2=7'h78 -> out_n=-24 (6'h28), err_cnt unchanged.
REQ-038 Arbitration: a_valid and b_valid high together from reset -> grant order A, B, A, B; out_id alternates 0,1,0,1; a_ready and b_ready never both high.
REQ-039 Reset: assert rst in DEC2 -> out_valid, out_n, err_cnt immediately 0; no out_valid for that pair; the next tie goes to A.
REQ-040 Saturation: 260 pairs with an error in both words -> err_cnt=255 and stays 255.

Source files
------------

// File: rtl/hd_sched_if.sv
// Request/result bundle for hd_sched: two code-word-pair requesters in, one
// decoded result stream plus status out.
interface hd_sched_if;
  logic       a_valid;
  logic [6:0] a_cw1;
  logic [6:0] a_cw2;
  logic       a_ready;
  logic       b_valid;
  logic [6:0] b_cw1;
  logic [6:0] b_cw2;
  logic       b_ready;
  logic       out_valid;
  logic       out_id;
  logic [5:0] out_n;
  logic       busy;
  logic [7:0] err_cnt;

  modport master (
    output a_valid, a_cw1, a_cw2, b_valid, b_cw1, b_cw2,
    input  a_ready, b_ready, out_valid, out_id, out_n, busy, err_cnt
  );

  modport slave (
    input  a_valid, a_cw1, a_cw2, b_valid, b_cw1, b_cw2,
    output a_ready, b_ready, out_valid, out_id, out_n, busy, err_cnt
  );
endinterface

// File: rtl/hd_sched.sv
// Round-robin scheduler feeding one time-shared Hamming(7,4) decoder; each
// granted pair is decoded word by word and combined by the flag-selected rule.
module hd_dec (
  input  logic [6:0]        cw,
  output logic signed [3:0] w,
  output logic              f,
  output logic              err
);
  logic [2:0] syn;
  logic [3:0] flip;

  always_comb begin
    syn[0] = cw[6] ^ cw[3] ^ cw[2] ^ cw[1];
    syn[1] = cw[5] ^ cw[3] ^ cw[2] ^ cw[0];
    syn[2] = cw[4] ^ cw[3] ^ cw[1] ^ cw[0];
    flip   = 4'b0000;
    f      = 1'b0;
    // w bit order is {x1,x2,x3,x4}; parity errors leave the data untouched
    case (syn)
      3'b001: f = cw[6];
      3'b010: f = cw[5];
      3'b011: begin flip = 4'b0100; f = cw[2]; end
      3'b100: f = cw[4];
      3'b101: begin flip = 4'b0010; f = cw[1]; end
      3'b110: begin flip = 4'b0001; f = cw[0]; end
      3'b111: begin flip = 4'b1000; f = cw[3]; end
      default: f = 1'b0;
    endcase
    w   = cw[3:0] ^ flip;
    err = |syn;
  end
endmodule

module hd_sched (
  input logic       clk,
  input logic       rst,
  hd_sched_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DEC1, DEC2, DONE} state_t;

  state_t            state_q, state_d;
  logic              last_b_q, last_b_d;
  logic [6:0]        cw1_q, cw1_d, cw2_q, cw2_d;
  logic              id_q, id_d;
  logic signed [3:0] w1_q, w1_d;
  logic              f1_q, f1_d;
  logic              out_valid_q, out_valid_d;
  logic              out_id_q, out_id_d;
  logic [5:0]        out_n_q, out_n_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic              idle, a_win, b_win, a_gnt, b_gnt;
  logic [6:0]        dec_cw;
  logic signed [3:0] dec_w;
  logic              dec_f, dec_err;
  logic signed [5:0] w1x, w2x, res;

  assign idle  = (state_q == IDLE);
  // on a tie the requester not granted last wins
  assign a_win = bus.a_valid & (~bus.b_valid | last_b_q);
  assign b_win = bus.b_valid & ~a_win;
  assign a_gnt = idle & a_win;
  assign b_gnt = idle & b_win;

  assign dec_cw = (state_q == DEC2) ? cw2_q : cw1_q;

  hd_dec u_dec (.cw(dec_cw), .w(dec_w), .f(dec_f), .err(dec_err));

  assign w1x = {{2{w1_q[3]}}, w1_q};
  assign w2x = {{2{dec_w[3]}}, dec_w};

  always_comb begin
    case ({f1_q, dec_f})
      2'b00:   res = w1x + w1x + w2x;
      2'b01:   res = w1x + w1x - w2x;
      2'b10:   res = w1x - w2x - w2x;
      default: res = w1x + w2x + w2x;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    last_b_d    = last_b_q;
    cw1_d       = cw1_q;
    cw2_d       = cw2_q;
    id_d        = id_q;
    w1_d        = w1_q;
    f1_d        = f1_q;
    out_valid_d = 1'b0;
    out_id_d    = out_id_q;
    out_n_d     = out_n_q;
    err_cnt_d   = err_cnt_q;
    case (state_q)
      IDLE: if (a_gnt | b_gnt) begin
        cw1_d    = a_gnt ? bus.a_cw1 : bus.b_cw1;
        cw2_d    = a_gnt ? bus.a_cw2 : bus.b_cw2;
        id_d     = b_gnt;
        last_b_d = b_gnt;
        state_d  = DEC1;
      end
      DEC1: begin
        w1_d    = dec_w;
        f1_d    = dec_f;
        state_d = DEC2;
      end
      DEC2: begin
        out_n_d     = res;
        out_id_d    = id_q;
        out_valid_d = 1'b1;
        state_d     = DONE;
      end
      default: state_d = IDLE;
    endcase
    if ((state_q == DEC1 || state_q == DEC2) && dec_err && err_cnt_q != 8'hFF)
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_b_q    <= 1'b1;
      cw1_q       <= '0;
      cw2_q       <= '0;
      id_q        <= 1'b0;
      w1_q        <= '0;
      f1_q        <= 1'b0;
      out_valid_q <= 1'b0;
      out_id_q    <= 1'b0;
      out_n_q     <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_b_q    <= last_b_d;
      cw1_q       <= cw1_d;
      cw2_q       <= cw2_d;
      id_q        <= id_d;
      w1_q        <= w1_d;
      f1_q        <= f1_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      out_n_q     <= out_n_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign bus.a_ready   = a_gnt;
  assign bus.b_ready   = b_gnt;
  assign bus.out_valid = out_valid_q;
  assign bus.out_id    = out_id_q;
  assign bus.out_n     = out_n_q;
  assign bus.busy      = ~idle;
  assign bus.err_cnt   = err_cnt_q;
endmodule

// File: tb/tb_hd_sched.sv
// Scoreboard bench for hd_sched: a nearest-codeword reference model predicts
// grants and results; a negedge monitor checks every cycle.
module tb_hd_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  hd_sched_if bus();
  hd_sched dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int         due;
    logic       id;
    logic [5:0] n;
    logic [7:0] err;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   m_busy = 0;
  bit   m_last_b = 1'b1;
  int   m_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [6:0] enc(input logic [3:0] d);
    return {d[3]^d[2]^d[1], d[3]^d[2]^d[0], d[3]^d[1]^d[0], d};
  endfunction

  // Nearest valid code word (the code is perfect, so distance <= 1 always exists)
  task automatic ref_dec(input logic [6:0] cw, output int w, output bit f, output bit e);
    logic [6:0] diff;
    w = 0; f = 0; e = 0;
    for (int d = 0; d < 16; d++) begin
      diff = cw ^ enc(d[3:0]);
      if ($countones(diff) <= 1) begin
        w = (d >= 8) ? d - 16 : d;
        e = (diff != 0);
        f = |(cw & diff);
      end
    end
  endtask

  task automatic predict(input logic id, input logic [6:0] c1, input logic [6:0] c2);
    int w1, w2, r;
    bit f1, f2, e1, e2;
    exp_t x;
    ref_dec(c1, w1, f1, e1);
    ref_dec(c2, w2, f2, e2);
    if (!f1 && !f2)     r = 2*w1 + w2;
    else if (!f1 && f2) r = 2*w1 - w2;
    else if (f1 && !f2) r = w1 - 2*w2;
    else                r = w1 + 2*w2;
    m_err = m_err + int'(e1) + int'(e2);
    if (m_err > 255) m_err = 255;
    x.due = cyc + 3;
    x.id  = id;
    x.n   = r[5:0];
    x.err = m_err[7:0];
    sbq.push_back(x);
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit ea, eb;
    cyc++;
    if (!rst) begin
      if (bus.out_valid) begin
        if (sbq.size() == 0) chk("spurious_out_valid", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("latency", cyc, e.due);
          chk("out_id", bus.out_id, e.id);
          chk("out_n", bus.out_n, e.n);
          chk("err_cnt", bus.err_cnt, e.err);
        end
      end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        chk("missing_out_valid", 0, 1);
        void'(sbq.pop_front());
      end
      chk("ready_exclusive", bus.a_ready & bus.b_ready, 0);
      if (m_busy > 0) begin
        chk("busy", bus.busy, 1);
        chk("ready_while_busy", {bus.a_ready, bus.b_ready}, 0);
        m_busy--;
      end else begin
        chk("busy", bus.busy, 0);
        ea = bus.a_valid & (!bus.b_valid | m_last_b);
        eb = bus.b_valid & !ea;
        chk("grant", {bus.a_ready, bus.b_ready}, {ea, eb});
        if (ea || eb) begin
          if (ea) predict(1'b0, bus.a_cw1, bus.a_cw2);
          else    predict(1'b1, bus.b_cw1, bus.b_cw2);
          m_last_b = eb;
          m_busy   = 3;
        end
      end
    end
  end

  task automatic run_a(input logic [6:0] c1, input logic [6:0] c2,
                       input logic [5:0] exp_n, input logic [7:0] exp_err);
    bit got;
    @(posedge clk); #1;
    bus.a_valid = 1'b1; bus.a_cw1 = c1; bus.a_cw2 = c2; bus.b_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (bus.a_ready) got = 1;
    end
    if (!got) chk("a_grant_timeout", 0, 1);
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        got = 1;
        chk("dir_out_n", bus.out_n, exp_n);
        chk("dir_err_cnt", bus.err_cnt, exp_err);
      end
    end
    if (!got) chk("out_valid_timeout", 0, 1);
  endtask

  task automatic model_reset();
    sbq.delete();
    m_busy   = 0;
    m_last_b = 1'b1;
    m_err    = 0;
  endtask

  initial begin
    bus.a_valid = 0; bus.a_cw1 = 0; bus.a_cw2 = 0;
    bus.b_valid = 0; bus.b_cw1 = 0; bus.b_cw2 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_n", bus.out_n, 0);
    chk("rst_out_id", bus.out_id, 0);
    chk("rst_err_cnt", bus.err_cnt, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b0;

    run_a(7'h75, 7'h4F, 6'd1,  8'd2);
    run_a(7'h55, 7'h4E, 6'd8,  8'd2);
    run_a(7'h75, 7'h4E, 6'd9,  8'd3);
    run_a(7'h55, 7'h4F, 6'd12, 8'd4);
    run_a(7'h78, 7'h78, 6'h28, 8'd4);

    // reset while the next pair sits in DEC2
    @(posedge clk); #1;
    bus.a_valid = 1'b1; bus.a_cw1 = 7'h75; bus.a_cw2 = 7'h4F;
    for (int i = 0; i < 20 && !bus.a_ready; i++) @(negedge clk);
    @(posedge clk); #1;
    bus.a_valid = 1'b0;
    @(posedge clk); #2;
    model_reset();
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_out_n", bus.out_n, 0);
    chk("mid_rst_err_cnt", bus.err_cnt, 0);
    chk("mid_rst_busy", bus.busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // tie from reset: A first, then alternate
    bus.a_valid = 1'b1; bus.b_valid = 1'b1;
    @(negedge clk);
    chk("tie_first_a", {bus.a_ready, bus.b_ready}, 2'b10);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      bus.a_cw1 = 7'($urandom); bus.a_cw2 = 7'($urandom);
      bus.b_cw1 = 7'($urandom); bus.b_cw2 = 7'($urandom);
    end

    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      bus.a_valid = 1'($urandom);
      bus.b_valid = 1'($urandom);
      bus.a_cw1 = 7'($urandom); bus.a_cw2 = 7'($urandom);
      bus.b_cw1 = 7'($urandom); bus.b_cw2 = 7'($urandom);
    end

    // every word carries one flipped bit: drives err_cnt into saturation
    bus.a_valid = 1'b1; bus.b_valid = 1'b1;
    for (int i = 0; i < 1100; i++) begin
      @(posedge clk); #1;
      bus.a_cw1 = enc(4'($urandom)) ^ (7'd1 << $urandom_range(6, 0));
      bus.a_cw2 = enc(4'($urandom)) ^ (7'd1 << $urandom_range(6, 0));
      bus.b_cw1 = enc(4'($urandom)) ^ (7'd1 << $urandom_range(6, 0));
      bus.b_cw2 = enc(4'($urandom)) ^ (7'd1 << $urandom_range(6, 0));
    end
    @(posedge clk); #1;
    bus.a_valid = 1'b0; bus.b_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("err_cnt_saturated", bus.err_cnt, 8'd255);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end
endmodule
